sqrt_rsqrt_iter_unit: RTL and testbench
=======================================

Name: sqrt_rsqrt_iter_unit

Overview:
Parametrised iterative mantissa square-root / inverse-square-root engine for the lampFPU datapath. It is the successor to the fixed-width sqrt core. It computes a radix-2 restoring square root over a generic mantissa width. For inverse sqrt it follows with a restoring division. Valid/ready handshakes are provided on both input and output. It sits between the FPU operand unpack/exponent logic and the result normaliser/packer.

Parameters:
MANT_W, 1+LAMP_FLOAT_F_DW (8), mantissa width including hidden bit; legal range 4..32.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
in_valid_i  in  1  operand valid
in_ready_o  out  1  unit can accept operand
s_i  in  MANT_W  mantissa 1.(MANT_W-1), s_i[MANT_W-1]=1 for normal operands
is_exp_odd_i  in  1  unbiased exponent odd -> radicand doubled
invSqrt_i  in  1  1 = 1/sqrt, 0 = sqrt
special_case_i  in  1  bypass: result = s_i unchanged
valid_o  out  1  result valid, held until ready_i
ready_i  in  1  downstream accepts result
res_o  out  MANT_W  result mantissa 1.(MANT_W-1)
exp_adj_o  out  1  rsqrt only: caller decrements result exponent by 1

Behaviour:
- Reset (rst=0 at edge): state IDLE, in_ready_o=0 during reset then 1, valid_o=0, res_o=0, exp_adj_o=0, all internal regs cleared. Reset mid-operation aborts the transaction; no result is emitted.
- States: IDLE, SQRT, DIV, DONE. in_ready_o = (state==IDLE). Operands captured only on accept (in_valid_i & in_ready_o); later input changes are ignored.
- Accept with special_case_i=1: IDLE->DONE; res_o=s_i, exp_adj_o=0; valid_o high 1 cycle after the accept edge.
- Accept otherwise: IDLE->SQRT; load radicand N = (is_exp_odd_i ? s_i<<1 : s_i) << (MANT_W-1), width 2*MANT_W; iteration counter = MANT_W.
- SQRT: one result bit per cycle, MSB first (restoring: trial = (rem<<2 | next 2 radicand bits) - (Q<<2|1)). After MANT_W cycles Q = floor(sqrt(N)), Q in [2^(MANT_W-1), 2^MANT_W).
  - invSqrt=0: ->DONE, res_o=Q, exp_adj_o=0.
  - invSqrt=1: ->DIV.
- DIV: restoring division of 2^(2*MANT_W-1) by Q, one quotient bit per cycle, MANT_W cycles.
  - If Q==2^(MANT_W-1): skip the division (exact 1.0); res_o=2^(MANT_W-1), exp_adj_o=0; DIV lasts 1 cycle.
  - Else: res_o=floor(2^(2*MANT_W-1)/Q), exp_adj_o=1.
- Latency, accept edge to valid_o high: special 1; sqrt MANT_W; rsqrt 2*MANT_W (MANT_W+1 for the exact-1.0 case).
- DONE: valid_o=1, res_o/exp_adj_o stable. On an edge with ready_i=1: ->IDLE, valid_o=0. res_o holds its last value in IDLE. No accept is possible in the DONE cycle; minimum issue interval is latency+1.
- ready_i asserted before valid_o has no effect. in_valid_i while busy is not consumed; the upstream holds it.
- The operand s_i with hidden bit 0 is outside contract; the unit still terminates with the same latency.

Optional Feature:
SQRT_RND_EN
- Defined: each iterative phase (SQRT, DIV) runs one extra cycle to produce a guard bit. The phase result is rounded half-up, saturating at 2^MANT_W-1.
  - rsqrt divides using the truncated Q.
  - Latencies become MANT_W+1 and 2*MANT_W+2; special case and the exact-1.0 path are unchanged.
- Undefined: truncation only, latencies as above.

Test Plan:
1. MANT_W=8, s_i=8'b11111000, odd=0, inv=0 -> after 8 cycles valid_o=1, res_o=8'b10110010 (178), exp_adj_o=0.
2. Same operand, inv=1 -> after 16 cycles res_o=8'b10111000 (184), exp_adj_o=1. Hold ready_i=0 for 3 cycles -> outputs stable, in_ready_o=0.
3. s_i=8'h80, odd=1, inv=1 -> Q=181, res_o=181 (8'hB5), exp_adj_o=1. Then s_i=8'h80, odd=0, inv=1 -> res_o=8'h80, exp_adj_o=0 after 9 cycles.
4. special_case_i=1, s_i=8'hC3 -> valid_o 1 cycle after accept, res_o=8'hC3, exp_adj_o=0.
5. rst=0 asserted 3 cycles into an rsqrt -> next cycle valid_o=0, res_o=0. After release, a new sqrt of 8'hFF with odd=1 -> res_o=8'hFF.
6. SQRT_RND_EN defined: s_i=8'b11111000, odd=0, inv=0 -> res_o=178 after 9 cycles. Randomised MANT_W=12 sweep checked against the floor/round reference model.

Source files
------------

// File: rtl/sqrt_rsqrt_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_rsqrt_iter_unit
// Brief    : Iterative radix-2 restoring mantissa sqrt / 1/sqrt engine with
//            valid/ready handshakes. Define SQRT_RND_EN for guard-bit rounding.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_rsqrt_iter_unit #(
    parameter int MANT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [MANT_W-1:0] s_i,
    input  logic              is_exp_odd_i,
    input  logic              invSqrt_i,
    input  logic              special_case_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [MANT_W-1:0] res_o,
    output logic              exp_adj_o
);

`ifdef SQRT_RND_EN
    localparam int c_g_w = 1;
`else
    localparam int c_g_w = 0;
`endif
    // Phase results carry an optional guard bit below the MANT_W result bits.
    localparam int c_q_w   = MANT_W + c_g_w;
    localparam int c_rem_w = c_q_w + 2;
    localparam int c_trl_w = c_q_w + 4;
    localparam int c_div_w = MANT_W + 2;
    localparam int c_cnt_w = $clog2(c_q_w + 1);
    localparam logic [c_cnt_w-1:0] c_iters    = c_cnt_w'(c_q_w);
    localparam logic [MANT_W-1:0]  c_one      = {1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [c_div_w-1:0] c_div_init = {2'b01, {MANT_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQRT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*MANT_W-1:0]  r_rad;
    logic [c_rem_w-1:0]   r_rem;
    logic [c_q_w-1:0]     r_q;
    logic [c_div_w-1:0]   r_drem;
    logic [c_q_w-2:0]     r_dq;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_inv;
    logic [MANT_W-1:0]    r_res;
    logic                 r_adj;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_idle;
    logic [2*MANT_W-1:0]  w_rad_init;
    logic [2*MANT_W-1:0]  w_rad_src;
    logic [c_rem_w-1:0]   w_rem_src;
    logic [c_q_w-1:0]     w_q_src;
    logic [c_trl_w-1:0]   w_trial_in;
    logic [c_trl_w-1:0]   w_trial_sub;
    logic                 w_sq_bit;
    logic [2*MANT_W-1:0]  w_rad_nxt;
    logic [c_rem_w-1:0]   w_rem_nxt;
    logic [c_q_w-1:0]     w_q_nxt;
    logic [MANT_W-1:0]    w_q_trunc;
    logic                 w_exact;
    logic                 w_div_bit;
    logic [c_div_w-1:0]   w_drem_sub;
    logic [c_div_w-1:0]   w_drem_nxt;
    logic [c_q_w-1:0]     w_dq_nxt;

    // Rounds half-up on the guard bit when enabled, saturating at all-ones.
    function automatic logic [MANT_W-1:0] phase_result(input logic [c_q_w-1:0] v);
`ifdef SQRT_RND_EN
        logic [MANT_W:0] sum;
        sum = {1'b0, v[c_q_w-1:1]} + {{MANT_W{1'b0}}, v[0]};
        return sum[MANT_W] ? {MANT_W{1'b1}} : sum[MANT_W-1:0];
`else
        return v;
`endif
    endfunction

    assign w_idle     = (r_state == S_IDLE);
    assign in_ready_o = rst & w_idle;
    assign w_accept   = in_valid_i & in_ready_o;
    assign w_last     = (r_cnt == c_cnt_w'(1));
    assign w_rad_init = is_exp_odd_i ? {s_i, 1'b0, {(MANT_W-1){1'b0}}}
                                     : {1'b0, s_i, {(MANT_W-1){1'b0}}};

    // The first root bit is resolved on the accept edge from the fresh operand.
    assign w_rad_src   = w_idle ? w_rad_init : r_rad;
    assign w_rem_src   = w_idle ? '0 : r_rem;
    assign w_q_src     = w_idle ? '0 : r_q;
    assign w_trial_in  = {w_rem_src, w_rad_src[2*MANT_W-1 -: 2]};
    assign w_trial_sub = {2'b00, w_q_src, 2'b01};
    assign w_sq_bit    = (w_trial_in >= w_trial_sub);
    assign w_rem_nxt   = w_sq_bit ? (w_trial_in[c_rem_w-1:0] - w_trial_sub[c_rem_w-1:0])
                                  : w_trial_in[c_rem_w-1:0];
    assign w_q_nxt     = {w_q_src[c_q_w-2:0], w_sq_bit};
    assign w_rad_nxt   = {w_rad_src[2*MANT_W-3:0], 2'b00};

    // Division always uses the truncated root, guard bit dropped.
    assign w_q_trunc  = r_q[c_q_w-1 -: MANT_W];
    assign w_exact    = (w_q_trunc == c_one);
    assign w_div_bit  = (r_drem >= {2'b00, w_q_trunc});
    assign w_drem_sub = r_drem - {2'b00, w_q_trunc};
    assign w_drem_nxt = w_div_bit ? (w_drem_sub << 1) : (r_drem << 1);
    assign w_dq_nxt   = {r_dq, w_div_bit};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = special_case_i ? S_DONE : S_SQRT;
            S_SQRT: if (w_last)   w_state_nxt = r_inv ? S_DIV : S_DONE;
            S_DIV:  if (w_exact || w_last) w_state_nxt = S_DONE;
            S_DONE: if (ready_i)  w_state_nxt = S_IDLE;
            default:              w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_drem <= '0;
            r_dq   <= '0;
            r_cnt  <= '0;
            r_inv  <= 1'b0;
            r_res  <= '0;
            r_adj  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_inv <= invSqrt_i;
                    if (special_case_i) begin
                        r_res <= s_i;
                        r_adj <= 1'b0;
                    end else begin
                        r_rad <= w_rad_nxt;
                        r_rem <= w_rem_nxt;
                        r_q   <= w_q_nxt;
                        r_cnt <= c_iters - 1'b1;
                    end
                end
                S_SQRT: begin
                    r_rad <= w_rad_nxt;
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        if (r_inv) begin
                            r_drem <= c_div_init;
                            r_dq   <= '0;
                            r_cnt  <= c_iters;
                        end else begin
                            r_res <= phase_result(w_q_nxt);
                            r_adj <= 1'b0;
                        end
                    end
                end
                S_DIV: begin
                    r_drem <= w_drem_nxt;
                    r_dq   <= w_dq_nxt[c_q_w-2:0];
                    r_cnt  <= r_cnt - 1'b1;
                    if (w_exact) begin
                        r_res <= c_one;
                        r_adj <= 1'b0;
                    end else if (w_last) begin
                        r_res <= phase_result(w_dq_nxt);
                        r_adj <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_o   = (r_state == S_DONE);
    assign res_o     = r_res;
    assign exp_adj_o = r_adj;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_rsqrt_iter_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_rsqrt_iter_unit
// Brief    : Directed self-checking bench for sqrt_rsqrt_iter_unit (MANT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_rsqrt_iter_unit;

    localparam int MANT_W = 8;
`ifdef SQRT_RND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int LAT_SP  = 1;
    localparam int LAT_SQ  = MANT_W + RND;
    localparam int LAT_RSQ = 2*MANT_W + 2*RND;
    localparam int LAT_EX  = LAT_SQ + 1;

    logic              clk_tb = 1'b0;
    logic              rst;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [MANT_W-1:0] s_i;
    logic              is_exp_odd_i;
    logic              invSqrt_i;
    logic              special_case_i;
    logic              valid_o;
    logic              ready_i;
    logic [MANT_W-1:0] res_o;
    logic              exp_adj_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_tb = ~clk_tb;

    sqrt_rsqrt_iter_unit #(.MANT_W(MANT_W)) dut (
        .clk            (clk_tb),
        .rst            (rst),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .s_i            (s_i),
        .is_exp_odd_i   (is_exp_odd_i),
        .invSqrt_i      (invSqrt_i),
        .special_case_i (special_case_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .res_o          (res_o),
        .exp_adj_o      (exp_adj_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operand, scramble the inputs after accept, measure latency,
    // optionally stall the result, then drain it.
    task automatic run_op(input string tag, input logic [7:0] s, input logic odd,
                          input logic inv, input logic sp, input logic [7:0] exp_res,
                          input logic exp_adj, input int exp_lat, input int hold,
                          input logic early_rdy);
        int lat;
        @(negedge clk_tb);
        chk({tag, "/in_ready_idle"}, in_ready_o, 1);
        s_i = s; is_exp_odd_i = odd; invSqrt_i = inv; special_case_i = sp;
        in_valid_i = 1'b1;
        ready_i = early_rdy;
        @(posedge clk_tb);
        @(negedge clk_tb);
        in_valid_i = 1'b0;
        s_i = ~s; is_exp_odd_i = ~odd; invSqrt_i = ~inv; special_case_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 200) begin
            @(negedge clk_tb);
            lat++;
        end
        chk({tag, "/latency"}, lat, exp_lat);
        chk({tag, "/res"}, res_o, exp_res);
        chk({tag, "/exp_adj"}, exp_adj_o, exp_adj);
        chk({tag, "/in_ready_busy"}, in_ready_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_tb);
            chk({tag, "/hold_valid"}, valid_o, 1);
            chk({tag, "/hold_res"}, res_o, exp_res);
            chk({tag, "/hold_in_ready"}, in_ready_o, 0);
        end
        ready_i = 1'b1;
        @(negedge clk_tb);
        ready_i = 1'b0;
        chk({tag, "/drained_valid"}, valid_o, 0);
        chk({tag, "/drained_in_ready"}, in_ready_o, 1);
        chk({tag, "/idle_res_held"}, res_o, exp_res);
    endtask

    initial begin
        int seen;
        rst = 1'b0; in_valid_i = 1'b0; s_i = '0; is_exp_odd_i = 1'b0;
        invSqrt_i = 1'b0; special_case_i = 1'b0; ready_i = 1'b0;

        repeat (3) @(negedge clk_tb);
        chk("reset/valid", valid_o, 0);
        chk("reset/res", res_o, 0);
        chk("reset/exp_adj", exp_adj_o, 0);
        chk("reset/in_ready", in_ready_o, 0);
        rst = 1'b1;
        @(negedge clk_tb);
        chk("reset/in_ready_after", in_ready_o, 1);

        // 248 << 7 = 31744, floor sqrt 178; 32768/178 = 184
        run_op("sqrt_f8",   8'hF8, 1'b0, 1'b0, 1'b0, 8'hB2, 1'b0, LAT_SQ,  0, 1'b0);
        run_op("rsqrt_f8",  8'hF8, 1'b0, 1'b1, 1'b0, 8'hB8, 1'b1, LAT_RSQ, 3, 1'b0);
        // 256 << 7 = 32768, sqrt 181; 32768/181 = 181
        run_op("rsqrt_80o", 8'h80, 1'b1, 1'b1, 1'b0, 8'hB5, 1'b1, LAT_RSQ, 0, 1'b0);
        run_op("rsqrt_80e", 8'h80, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, LAT_EX,  0, 1'b0);
        run_op("special",   8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, LAT_SP,  1, 1'b0);
        run_op("sqrt_80e",  8'h80, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, LAT_SQ,  0, 1'b1);
        // 255 << 7 = 32640: sqrt 180.66 -> 180 truncated, 181 rounded
        run_op("sqrt_ffe",  8'hFF, 1'b0, 1'b0, 1'b0, (RND != 0) ? 8'hB5 : 8'hB4,
               1'b0, LAT_SQ, 0, 1'b0);
        // 32768/180 = 182.04
        run_op("rsqrt_ffe", 8'hFF, 1'b0, 1'b1, 1'b0, 8'hB6, 1'b1, LAT_RSQ, 0, 1'b0);
        run_op("rsqrt_pre", 8'h80, 1'b1, 1'b1, 1'b0, 8'hB5, 1'b1, LAT_RSQ, 0, 1'b0);

        // Abort an rsqrt three cycles in
        @(negedge clk_tb);
        s_i = 8'hF8; is_exp_odd_i = 1'b0; invSqrt_i = 1'b1; in_valid_i = 1'b1;
        @(posedge clk_tb);
        @(negedge clk_tb);
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk_tb);
        rst = 1'b0;
        @(negedge clk_tb);
        chk("abort/valid", valid_o, 0);
        chk("abort/res", res_o, 0);
        chk("abort/exp_adj", exp_adj_o, 0);
        chk("abort/in_ready", in_ready_o, 0);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk_tb);
            if (valid_o) seen++;
        end
        chk("abort/no_result", seen, 0);

        // 510 << 7 = 65280, sqrt 255.5 -> 255 both modes
        run_op("sqrt_ffo",  8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, LAT_SQ, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
